// File: rtl/ic_bd_pkg.sv
// Purpose : shared constants for the BinDCT row/column transform blocks.
// Contents: default widths, lifting constants as numerator/shift pairs,
//           row-packing helper (coefficient/sample 0 sits in the MSBs).
package ic_bd_pkg;

    localparam int DEF_IN_W  = 12;
    localparam int DEF_OUT_W = 12;
    localparam int DEF_INT_W = 16;

    localparam int ROW_N = 8;

    // Lifting multipliers, value = NUM / 2^SH
    localparam int K13_NUM = 13;  localparam int K13_SH = 5;   // 13/32
    localparam int K11_NUM = 11;  localparam int K11_SH = 4;   // 11/16
    localparam int K15_NUM = 15;  localparam int K15_SH = 4;   // 15/16
    localparam int K3_NUM  = 3;   localparam int K3_SH  = 3;   // 3/8
    localparam int K1_NUM  = 1;   localparam int K1_SH  = 3;   // 1/8
    localparam int K7_NUM  = 7;   localparam int K7_SH  = 3;   // 7/8
    localparam int KH_NUM  = 1;   localparam int KH_SH  = 1;   // 1/2

    // LSB position of element idx in a packed row of ROW_N elements of width w
    function automatic int slot_lsb(input int idx, input int w);
        return (ROW_N - 1 - idx) * w;
    endfunction

endpackage

// File: rtl/ic_bd_clamp.sv
// Purpose : reduce one internal-width coefficient to OUT_W bits.
// Ports   : din (signed, INT_W) -> dout (OUT_W). Purely combinational.
// Build   : IC_BD_ROW_DCT_SATURATE_EN defined -> clamp to OUT_W signed range,
//           otherwise two's-complement wrap (keep the low OUT_W bits).
module ic_bd_clamp
    import ic_bd_pkg::*;
#(
    parameter int INT_W = DEF_INT_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [INT_W-1:0] din,
    output logic        [OUT_W-1:0] dout
);

`ifdef IC_BD_ROW_DCT_SATURATE_EN
    localparam logic signed [INT_W-1:0] MAXV = INT_W'((2 ** (OUT_W - 1)) - 1);
    // ~(2^(n-1)-1) == -2^(n-1)
    localparam logic signed [INT_W-1:0] MINV = ~MAXV;

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAXV) begin
            dout = MAXV[OUT_W-1:0];
        end else if (din < MINV) begin
            dout = MINV[OUT_W-1:0];
        end
    end
`else
    // High bits are intentionally dropped in the wrapping build.
    logic unused_hi;
    assign unused_hi = ^din[INT_W-1:OUT_W];
    assign dout      = din[OUT_W-1:0];
`endif

endmodule

// File: rtl/ic_bd_row_dct.sv
// Purpose : pipelined 8-point BinDCT (lifting, shift-add only), one row in, one
//           coefficient row out per transfer; feeds the transpose buffer write side.
// Ports   : clk, reset_n (sync, active-low); in_valid/in_ready/in_row (x0 in MSBs);
//           out_valid/out_ready/out_row (X0 in MSBs); block_done pulses on the
//           8th output transfer of each block.
// Timing  : 4 register stages, latency 4, 1 row/cycle; the whole pipe freezes while
//           out_valid & ~out_ready. IC_BD_ROW_DCT_SATURATE_EN selects clamp vs wrap.
module ic_bd_row_dct
    import ic_bd_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int INT_W = DEF_INT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_row,
    output logic                 block_done
);

    typedef logic signed [INT_W-1:0] word_t;

    // (v * num) >>> sh with num < 16. The product is formed 4 bits wider than
    // INT_W so the intermediate cannot overflow before the floor shift.
    function automatic word_t lift(input word_t v, input int num, input int sh);
        logic signed [INT_W+3:0] ve;
        logic signed [INT_W+3:0] acc;
        ve  = (INT_W + 4)'(v);
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (((num >> i) & 1) != 0) begin
                acc = acc + (ve <<< i);
            end
        end
        acc = acc >>> sh;
        return acc[INT_W-1:0];
    endfunction

    logic advance;
    logic v1, v2, v3;
    logic [2:0] row_cnt;

    assign advance    = ~out_valid | out_ready;
    assign in_ready   = advance;
    assign block_done = out_valid & out_ready & (row_cnt == 3'd7);

    // ---------------- S1: butterfly ----------------
    word_t x   [8];
    word_t a_n [8];
    word_t a   [8];

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        assign x[g] = INT_W'($signed(in_row[slot_lsb(g, IN_W) +: IN_W]));
    end

    always_comb begin
        a_n[0] = x[0] + x[7];
        a_n[1] = x[1] + x[6];
        a_n[2] = x[2] + x[5];
        a_n[3] = x[3] + x[4];
        a_n[4] = x[3] - x[4];
        a_n[5] = x[2] - x[5];
        a_n[6] = x[1] - x[6];
        a_n[7] = x[0] - x[7];
    end

    // ---------------- S2: even butterfly + first odd lifting pair ----------------
    word_t b0_n, b1_n, b2_n, b3_n, o5_n, o6_n;
    word_t b0, b1, b2, b3, o5, o6, a4_2, a7_2;

    always_comb begin
        b0_n = a[0] + a[3];
        b3_n = a[0] - a[3];
        b1_n = a[1] + a[2];
        b2_n = a[1] - a[2];
        o5_n = a[5] - lift(a[6], K13_NUM, K13_SH);
        o6_n = a[6] + lift(o5_n, K11_NUM, K11_SH);
    end

    // ---------------- S3 ----------------
    word_t x0_n, x4_n, x6_n, p_n, f4_n, f5_n, f6_n, f7_n;
    word_t x0_3, x4_3, x6_3, b3_3, f4, f5, f6, f7;

    always_comb begin
        x0_n = lift(b0 + b1, KH_NUM, KH_SH);
        x4_n = x0_n - b1;
        x6_n = lift(b3, K3_NUM, K3_SH) - b2;
        p_n  = lift(o6, K15_NUM, K15_SH) - o5;
        f4_n = a4_2 + p_n;
        f5_n = a4_2 - p_n;
        f6_n = a7_2 - o6;
        f7_n = a7_2 + o6;
    end

    // ---------------- S4: final lifting, reduction to OUT_W ----------------
    word_t c [8];
    logic [OUT_W-1:0]   q [8];
    logic [8*OUT_W-1:0] row_n;

    always_comb begin
        c[0] = x0_3;
        c[4] = x4_3;
        c[6] = x6_3;
        c[2] = b3_3 - lift(x6_3, K3_NUM, K3_SH);
        c[7] = lift(f7, K1_NUM, K1_SH) - f4;
        c[1] = f7 - lift(c[7], K1_NUM, K1_SH);
        c[5] = lift(f6, K7_NUM, K7_SH) + f5;
        c[3] = f6 - lift(c[5], KH_NUM, KH_SH);
    end

    for (genvar g = 0; g < 8; g++) begin : g_clamp
        ic_bd_clamp #(
            .INT_W (INT_W),
            .OUT_W (OUT_W)
        ) u_clamp (
            .din  (c[g]),
            .dout (q[g])
        );
        assign row_n[slot_lsb(g, OUT_W) +: OUT_W] = q[g];
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            row_cnt   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                a[i] <= '0;
            end
            b0   <= '0;  b1   <= '0;  b2   <= '0;  b3 <= '0;
            o5   <= '0;  o6   <= '0;  a4_2 <= '0;  a7_2 <= '0;
            x0_3 <= '0;  x4_3 <= '0;  x6_3 <= '0;  b3_3 <= '0;
            f4   <= '0;  f5   <= '0;  f6   <= '0;  f7 <= '0;
        end else begin
            // Data registers load on every advance; bubbles carry don't-care
            // data and are marked by their valid bit.
            if (advance) begin
                v1        <= in_valid;
                v2        <= v1;
                v3        <= v2;
                out_valid <= v3;
                a         <= a_n;
                b0   <= b0_n;  b1   <= b1_n;  b2   <= b2_n;  b3 <= b3_n;
                o5   <= o5_n;  o6   <= o6_n;  a4_2 <= a[4];  a7_2 <= a[7];
                x0_3 <= x0_n;  x4_3 <= x4_n;  x6_3 <= x6_n;  b3_3 <= b3;
                f4   <= f4_n;  f5   <= f5_n;  f6   <= f6_n;  f7 <= f7_n;
                out_row <= row_n;
            end
            if (out_valid && out_ready) begin
                row_cnt <= row_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ic_bd_row_dct.sv
module tb_ic_bd_row_dct;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_row = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [95:0] out_row;
    logic        block_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ic_bd_row_dct dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .block_done (block_done)
    );

    typedef struct {
        string       name;
        logic [95:0] row_in;
        logic [95:0] row_exp;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [95:0] mk(input int v0, input int v1, input int v2, input int v3,
                                       input int v4, input int v5, input int v6, input int v7);
        return {12'(v0), 12'(v1), 12'(v2), 12'(v3), 12'(v4), 12'(v5), 12'(v6), 12'(v7)};
    endfunction

    function automatic logic [95:0] dc(input int v);
        return mk(v, v, v, v, v, v, v, v);
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Stream n_send DC rows (value base+k+1 -> X0 = 4*(base+k+1)); stall out_ready
    // for cycles stall_lo..stall_hi; stop once n_stop rows have been received.
    task automatic stream(input int n_send, input int n_stop, input int stall_lo,
                          input int stall_hi, input int base);
        int          sent = 0;
        int          recv = 0;
        int          cyc = 0;
        logic        was_stall = 1'b0;
        logic [95:0] held = '0;
        while (recv < n_stop && cyc < 200) begin
            in_valid  = (sent < n_send);
            in_row    = dc(base + sent + 1);
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            #1;
            if (out_valid && !out_ready) begin
                chk("stall in_ready", 96'(in_ready), 96'(0));
                if (was_stall) chk("stall hold", out_row, held);
                held      = out_row;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("row order", out_row, mk(4 * (base + recv + 1), 0, 0, 0, 0, 0, 0, 0));
                chk("block_done on xfer", 96'(block_done), 96'(recv == 7));
                recv++;
            end else begin
                chk("block_done idle", 96'(block_done), 96'(0));
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream count", 96'(recv), 96'(n_stop));
    endtask

    initial begin
        int sat_x0;
        int lat;
        int quiet_bad;

`ifdef IC_BD_ROW_DCT_SATURATE_EN
        sat_x0 = 2047;
`else
        sat_x0 = -4;
`endif
        vecs[0] = '{"zero",     dc(0),                      dc(0)};
        vecs[1] = '{"dc10",     dc(10),                     mk(40, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2] = '{"dc-10",    dc(-10),                    mk(-40, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3] = '{"imp x0",   mk(1, 0, 0, 0, 0, 0, 0, 0), mk(0, 1, 1, 1, 0, 0, 0, 0)};
        vecs[4] = '{"imp x7",   mk(0, 0, 0, 0, 0, 0, 0, 1), mk(0, 0, 1, 0, 0, -1, 0, -1)};
        vecs[5] = '{"x3=4",     mk(0, 0, 0, 4, 0, 0, 0, 0), mk(2, 1, -3, -2, 2, 4, -2, -4)};
        vecs[6] = '{"x1=8",     mk(0, 8, 0, 0, 0, 0, 0, 0), mk(4, 6, 3, 1, -4, -12, -8, -7)};
        vecs[7] = '{"sat 2047", dc(2047),                   mk(sat_x0, 0, 0, 0, 0, 0, 0, 0)};

        // Reset state while reset_n is held low
        reset_n = 1'b0;
        step();
        step();
        chk("reset out_valid", 96'(out_valid), 96'(0));
        chk("reset block_done", 96'(block_done), 96'(0));
        chk("reset out_row", out_row, 96'(0));
        reset_n = 1'b1;
        step();
        chk("idle in_ready", 96'(in_ready), 96'(1));

        // Single rows: latency, value, block_done on the 8th
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_row   = vecs[i].row_in;
            step();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                step();
                lat++;
            end
            chk({vecs[i].name, " latency"}, 96'(lat), 96'(4));
            chk({vecs[i].name, " row"}, out_row, vecs[i].row_exp);
            chk({vecs[i].name, " block_done"}, 96'(block_done), 96'(i == 7));
            step();
        end

        // Reset with a row in flight: nothing emerges afterwards
        in_valid = 1'b1;
        in_row   = dc(3);
        step();
        in_valid = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) quiet_bad++;
            step();
        end
        chk("flushed row", 96'(quiet_bad), 96'(0));

        // Back-pressure: 10 rows, out_ready low on cycles 6..9
        do_reset();
        stream(10, 10, 6, 9, 0);

        // Mid-block reset after 5 outputs, then a fresh block of 8
        do_reset();
        stream(7, 5, -1, -1, 20);
        reset_n = 1'b0;
        step();
        chk("midreset out_valid", 96'(out_valid), 96'(0));
        chk("midreset block_done", 96'(block_done), 96'(0));
        reset_n = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) quiet_bad++;
            step();
        end
        chk("midreset no partial", 96'(quiet_bad), 96'(0));
        stream(8, 8, -1, -1, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic_bd_row_dct.md
Name: ic_bd_row_dct

Overview:
- Pipelined 1-D BinDCT (8-point, lifting/shift-add only, no multipliers) for the BinDCT processor.
- Accepts one 8-sample row per transfer and produces one 8-coefficient row per transfer.
- Sits directly upstream of the transpose buffer and drives its write side (writerequest / full). The same block is instantiated for the row pass and the column pass.

Parameters:
- IN_W, 12, signed width of each input sample
- OUT_W, 12, signed width of each output coefficient
- INT_W, 16, internal signed datapath width; must be ≥ IN_W+4

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- in_valid  in  1  input row present
- in_ready  out  1  block can accept the row this cycle
- in_row  in  8*IN_W  samples x0..x7; x0 in MSBs
- out_valid  out  1  coefficient row present; connects to transpose writerequest
- out_ready  in  1  downstream accepts; driven by ~full of the transpose buffer
- out_row  out  8*OUT_W  coefficients X0..X7; X0 in MSBs
- block_done  out  1  one-cycle pulse on the 8th accepted output row of a block

Interface: reset reset_n, synchronous, active-low; clock clk.

Behaviour:
- Reset: all stage valids = 0, out_valid = 0, out_row = 0, block_done = 0, row counter = 0.
- Pipeline: 4 register stages, each with its own valid bit.
  - advance = ~out_valid | out_ready. All stages shift together on advance and hold otherwise.
  - in_ready = advance.
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - Latency is exactly 4 cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 row/cycle.
  - Bubbles propagate as valid = 0.
- Arithmetic:
  - Signed, sign-extended to INT_W.
  - ">>>" is an arithmetic right shift (floor). Constant multiplies are implemented as shift-add.
- S1 (butterfly):
  - a0=x0+x7, a1=x1+x6, a2=x2+x5, a3=x3+x4
  - a7=x0−x7, a6=x1−x6, a5=x2−x5, a4=x3−x4
- S2:
  - b0=a0+a3, b3=a0−a3, b1=a1+a2, b2=a1−a2
  - o5=a5−((13·a6)>>>5); o6=a6+((11·o5)>>>4)
  - a4 and a7 are passed through.
- S3:
  - X0=(b0+b1)>>>1; X4=X0−b1
  - X6=((3·b3)>>>3)−b2
  - p=((15·o6)>>>4)−o5
  - f4=a4+p, f5=a4−p, f6=a7−o6, f7=a7+o6
  - b3 is passed through.
- S4 (output register):
  - X2=b3−((3·X6)>>>3)
  - X7=(f7>>>3)−f4; X1=f7−(X7>>>3)
  - X5=((7·f6)>>>3)+f5; X3=f6−(X5>>>1)
  - Each coefficient is reduced to OUT_W (see Optional Feature) before registering.
- Stall: while out_valid & ~out_ready, out_row and all stage registers hold; in_ready = 0.
- Row counter (3 bits):
  - Increments on each output transfer and wraps 7→0.
  - block_done = 1 in the cycle the output transfer occurs with counter = 7; otherwise 0.
- Simultaneous input and output transfer in the same cycle: both occur and the pipeline shifts normally.
- Reset asserted mid-operation: all in-flight rows are discarded and the counter clears on the next clk edge. No partial output is emitted.

Optional Feature:
- Macro: IC_BD_ROW_DCT_SATURATE_EN
- Defined: each coefficient is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Undefined: each coefficient is truncated to its low OUT_W bits (two's-complement wrap).
- Latency is identical in both builds.

Decomposition:
- Shared package ic_bd_pkg holds:
  - IN_W/OUT_W/INT_W defaults
  - lifting constants (13/32, 11/16, 15/16, 3/8, 1/8, 7/8, 1/2) as numerator/shift pairs
  - the row-packing order (X0 in MSBs)
- One natural sub-module: ic_bd_clamp (OUT_W reduction, saturate or wrap per macro). It is instantiated 8× in S4.

Test Plan:
- Reset, then all-zero row → after 4 cycles out_valid=1, out_row=0. Hold reset_n=0 → out_valid=0, block_done=0.
- DC row, all x=10 → X0=40, X1..X7=0, exactly 4 cycles after the input transfer.
- Impulse row x0=1, others 0 → X0..X7 = 0,1,1,1,0,0,0,0.
- Saturation row, all x=2047 → X0=2047 with SATURATE_EN; X0=−4 (0xFFC) without it. X1..X7=0 in both builds.
- Back-pressure: stream 10 rows with out_ready=0 for cycles 6–9 → in_ready=0 and out_row held during the stall, no row lost or duplicated, outputs in order. block_done pulses on the 8th output only.
- Mid-block reset: assert reset_n=0 after 5 output rows, then stream 8 rows → block_done pulses on the 8th post-reset row (counter restarted at 0).
